// File: rtl/cv32e40n_arb_pkg.sv
// Shared types for the CV32E40N data memory arbiter: master IDs and the OBI request payload.
package cv32e40n_arb_pkg;

  typedef enum logic {
    MST_CORE = 1'b0,
    MST_VEC  = 1'b1
  } arb_master_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

endpackage

// File: rtl/cv32e40n_arb_id_fifo.sv
// In-order FIFO of 1-bit master IDs, one entry per accepted-but-unanswered transaction.
module cv32e40n_arb_id_fifo
  import cv32e40n_arb_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  arb_master_e   push_mst_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o,
  output arb_master_e   head_o
);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_i) begin
      mem_d[wptr_q] = push_mst_i;
      wptr_d        = ptr_next(wptr_q);
    end
    if (pop_i) begin
      rptr_d = ptr_next(rptr_q);
    end
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = arb_master_e'(mem_q[rptr_q]);

endmodule

// File: rtl/cv32e40n_data_mem_arbiter.sv
// Arbitrates the core LSU and vector unit onto one OBI data port and routes responses in order.
// Optional grant/stall counters are built when CV32E40N_ARB_PERF_CNT_EN is defined.
module cv32e40n_data_mem_arbiter
  import cv32e40n_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             core_req_i,
  output logic             core_gnt_o,
  output logic             core_rvalid_o,
  input  logic             core_we_i,
  input  logic [3:0]       core_be_i,
  input  logic [31:0]      core_addr_i,
  input  logic [31:0]      core_wdata_i,
  output logic [31:0]      core_rdata_o,
  input  logic             vec_req_i,
  output logic             vec_gnt_o,
  output logic             vec_rvalid_o,
  input  logic             vec_we_i,
  input  logic [3:0]       vec_be_i,
  input  logic [31:0]      vec_addr_i,
  input  logic [31:0]      vec_wdata_i,
  output logic [31:0]      vec_rdata_o,
  input  logic             vec_lock_i,
  output logic             data_req_o,
  input  logic             data_gnt_i,
  input  logic             data_rvalid_i,
  output logic             data_we_o,
  output logic [3:0]       data_be_o,
  output logic [31:0]      data_addr_o,
  output logic [31:0]      data_wdata_o,
  input  logic [31:0]      data_rdata_i,
  output logic             err_o,
  output logic [CNT_W-1:0] perf_core_gnt_o,
  output logic [CNT_W-1:0] perf_vec_gnt_o,
  output logic [CNT_W-1:0] perf_stall_o
);

  localparam int unsigned FCW = $clog2(MAX_OUTSTANDING + 1);

  logic          fifo_full, fifo_empty;
  logic [FCW-1:0] fifo_count_unused;
  arb_master_e   fifo_head;

  logic          core_elig, vec_elig;
  logic          win_valid, accept, pop;
  arb_master_e   win_mst;
  obi_req_t      core_s, vec_s, fwd;

  arb_master_e   last_winner_q, last_winner_d;
  logic          held_valid_q, held_valid_d;
  arb_master_e   held_mst_q, held_mst_d;
  logic          err_q, err_d;

  assign core_s = '{we: core_we_i, be: core_be_i, addr: core_addr_i, wdata: core_wdata_i};
  assign vec_s  = '{we: vec_we_i,  be: vec_be_i,  addr: vec_addr_i,  wdata: vec_wdata_i};

  assign core_elig = core_req_i & ~vec_lock_i & ~fifo_full;
  assign vec_elig  = vec_req_i & ~fifo_full;

  // A stalled winner keeps the port only while it is still eligible; a lock drops a stalled core.
  always_comb begin
    win_valid = core_elig | vec_elig;
    win_mst   = MST_CORE;
    if (held_valid_q && ((held_mst_q == MST_CORE && core_elig) ||
                         (held_mst_q == MST_VEC  && vec_elig))) begin
      win_mst = held_mst_q;
    end else if (core_elig && vec_elig) begin
      win_mst = (last_winner_q == MST_VEC) ? MST_CORE : MST_VEC;
    end else if (vec_elig) begin
      win_mst = MST_VEC;
    end
  end

  always_comb begin
    fwd = '0;
    if (win_valid) begin
      fwd = (win_mst == MST_VEC) ? vec_s : core_s;
    end
  end

  assign accept       = win_valid & data_gnt_i;
  assign data_req_o   = win_valid;
  assign data_we_o    = fwd.we;
  assign data_be_o    = fwd.be;
  assign data_addr_o  = fwd.addr;
  assign data_wdata_o = fwd.wdata;
  assign core_gnt_o   = accept & (win_mst == MST_CORE);
  assign vec_gnt_o    = accept & (win_mst == MST_VEC);

  assign pop           = data_rvalid_i & ~fifo_empty;
  assign core_rvalid_o = pop & (fifo_head == MST_CORE);
  assign vec_rvalid_o  = pop & (fifo_head == MST_VEC);
  assign core_rdata_o  = data_rdata_i;
  assign vec_rdata_o   = data_rdata_i;

  always_comb begin
    last_winner_d = accept ? win_mst : last_winner_q;
    held_valid_d  = win_valid & ~data_gnt_i;
    held_mst_d    = win_mst;
    err_d         = err_q | (data_rvalid_i & fifo_empty);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_winner_q <= MST_VEC;
      held_valid_q  <= 1'b0;
      held_mst_q    <= MST_CORE;
      err_q         <= 1'b0;
    end else begin
      last_winner_q <= last_winner_d;
      held_valid_q  <= held_valid_d;
      held_mst_q    <= held_mst_d;
      err_q         <= err_d;
    end
  end

  assign err_o = err_q;

  cv32e40n_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (accept),
    .push_mst_i (win_mst),
    .pop_i      (pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count_unused),
    .head_o     (fifo_head)
  );

`ifdef CV32E40N_ARB_PERF_CNT_EN
  logic [CNT_W-1:0] perf_core_q, perf_core_d;
  logic [CNT_W-1:0] perf_vec_q, perf_vec_d;
  logic [CNT_W-1:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_core_d  = perf_core_q;
    perf_vec_d   = perf_vec_q;
    perf_stall_d = perf_stall_q;
    if (core_gnt_o && !(&perf_core_q)) perf_core_d = perf_core_q + 1'b1;
    if (vec_gnt_o && !(&perf_vec_q))   perf_vec_d  = perf_vec_q + 1'b1;
    if ((core_req_i | vec_req_i) && !accept && !(&perf_stall_q)) begin
      perf_stall_d = perf_stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_core_q  <= '0;
      perf_vec_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_core_q  <= perf_core_d;
      perf_vec_q   <= perf_vec_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_core_gnt_o = perf_core_q;
  assign perf_vec_gnt_o  = perf_vec_q;
  assign perf_stall_o    = perf_stall_q;
`else
  assign perf_core_gnt_o = '0;
  assign perf_vec_gnt_o  = '0;
  assign perf_stall_o    = '0;
`endif

endmodule

// File: doc/cv32e40n_data_mem_arbiter.md
Name: cv32e40n_data_mem_arbiter

Overview:
- Shares the single OBI-style data memory port between the core LSU and the vector accelerator (APU-side master).
- Forwards one master's request per cycle. Grant is combinational.
- Records the winner of each accepted request in an in-order ID FIFO and routes each rvalid back to the correct master.
- vec_lock_i (driven from the accelerator's mem_master_sel) gives the vector unit exclusive ownership during vector memory sequences.

Parameters:
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered transactions. Legal range 1..8.
- CNT_W, 16, performance counter width. Used only when the optional feature is enabled.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- core_req_i  in  1  core LSU request
- core_gnt_o  out  1  core grant
- core_rvalid_o  out  1  core response valid
- core_we_i  in  1  core write enable
- core_be_i  in  4  core byte enables
- core_addr_i  in  32  core address
- core_wdata_i  in  32  core write data
- core_rdata_o  out  32  core read data
- vec_req_i, vec_gnt_o, vec_rvalid_o, vec_we_i, vec_be_i, vec_addr_i, vec_wdata_i, vec_rdata_o: same directions, widths and meanings as core_*, for the vector unit
- vec_lock_i  in  1  vector exclusive ownership
- data_req_o  out  1  memory request
- data_gnt_i  in  1  memory grant
- data_rvalid_i  out-side  in  1  memory response valid
- data_we_o  out  1  memory write enable
- data_be_o  out  4  memory byte enables
- data_addr_o  out  32  memory address
- data_wdata_o  out  32  memory write data
- data_rdata_i  in  32  memory read data
- err_o  out  1  sticky protocol error
- perf_core_gnt_o  out  CNT_W  core grant count
- perf_vec_gnt_o  out  CNT_W  vector grant count
- perf_stall_o  out  CNT_W  stall cycle count

Behaviour:
- Reset: FIFO empty, count=0, last_winner=VEC (so core wins the first tie), err_o=0, all counters 0. All outputs 0 while no request is present.
- Eligibility:
  - core_elig = core_req_i & ~vec_lock_i & ~full
  - vec_elig = vec_req_i & ~full
  - full = (count == MAX_OUTSTANDING), evaluated on registered count only. There is no combinational path from data_rvalid_i to data_req_o.
- Arbitration:
  - Only one master eligible: that master wins.
  - Both eligible: round-robin against last_winner.
  - last_winner updates only on an accepted handshake (data_req_o & data_gnt_i).
  - A request that is stalled (req & ~gnt) keeps its win in following cycles: winner is held until granted. This satisfies the OBI rule that addr/we/be/wdata stay stable.
- Forwarding: data_req_o = winner's req. data_we/be/addr/wdata are muxed from the winner and forced to 0 when there is no winner.
- Grant: winner_gnt_o = data_gnt_i & data_req_o. Loser gnt = 0.
- ID FIFO:
  - 1-bit entries (0=core, 1=vec), depth MAX_OUTSTANDING, wrap-around read/write pointers.
  - Push on accepted handshake. Pop on data_rvalid_i.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Zero-latency memory (gnt and rvalid in the same cycle for the same transaction) is not supported: rvalid always refers to a transaction accepted in an earlier cycle.
- Response routing:
  - core_rvalid_o = data_rvalid_i & ~empty & head==0
  - vec_rvalid_o = data_rvalid_i & ~empty & head==1
  - data_rdata_i is broadcast to both rdata outputs.
- Lock:
  - Asserting vec_lock_i blocks new core requests from the next evaluation onward.
  - A core request already stalled mid-handshake when lock rises is dropped from arbitration. The core holds it and retries after unlock; this is legal because no grant was given.
  - Outstanding core responses still drain to the core during lock.
- Error: data_rvalid_i while the FIFO is empty sets err_o, which stays set until reset. The FIFO is not modified.
- Reset mid-operation clears the FIFO. Late responses after reset set err_o.

Optional Feature:
- CV32E40N_ARB_PERF_CNT_EN
  - Defined:
    - perf_core_gnt_o increments on each accepted core handshake.
    - perf_vec_gnt_o increments on each accepted vector handshake.
    - perf_stall_o increments on each cycle where some master requests and none is granted.
    - All three saturate at all-ones.
  - Undefined: the ports are present and tied to 0, and no counter flops are built.

Decomposition:
- Package cv32e40n_arb_pkg:
  - typedef enum logic {MST_CORE=1'b0, MST_VEC=1'b1} arb_master_e
  - typedef struct obi_req_t {we, be, addr, wdata}
- One sub-module: cv32e40n_arb_id_fifo, a parameterised 1-bit in-order FIFO with full, empty, count and head outputs.

Test Plan:
- Single core read to 0x100, gnt same cycle, rvalid 2 cycles later with rdata 0xDEADBEEF: core_rvalid_o=1 with rdata 0xDEADBEEF; vec_rvalid_o stays 0.
- Both masters requesting continuously, gnt always 1: grants alternate core, vec, core, vec. perf_core_gnt_o=perf_vec_gnt_o=2 after 4 cycles (feature enabled).
- MAX_OUTSTANDING=2, two accepted vec requests, no rvalid: third request sees data_req_o=0. After one rvalid, data_req_o=1 in the next cycle.
- vec_lock_i=1 with core_req_i=1 and vec_req_i=1 for 5 cycles: only vec granted (5 grants), core_gnt_o=0. Lock drops and core wins the next cycle.
- Interleaved order core(A), vec(B) accepted, then rvalids with 0x1, 0x2: core receives 0x1, then vec receives 0x2.
- data_rvalid_i pulse with empty FIFO: err_o=1 and stays 1. Asserting rst_ni=0 clears it to 0.
